// File: rtl/debug_unit_pkg.sv
// Shared types for debug_unit: command encodings, FSM states, and the layouts of
// the command and response GPIO frames.
package debug_unit_pkg;

  localparam int PAYLOAD_W   = 27;
  localparam int RSP_ADDR_W  = 9;
  localparam int RSP_DATA_W  = 16;

  localparam logic [3:0] CMD_NOP      = 4'd0;
  localparam logic [3:0] CMD_PIPE_RST = 4'd1;
  localparam logic [3:0] CMD_ADDR_SET = 4'd2;
  localparam logic [3:0] CMD_LOAD_LO  = 4'd3;
  localparam logic [3:0] CMD_LOAD_HI  = 4'd4;
  localparam logic [3:0] CMD_STEP     = 4'd5;
  localparam logic [3:0] CMD_RUN      = 4'd6;
  localparam logic [3:0] CMD_READ_LO  = 4'd7;
  localparam logic [3:0] CMD_READ_HI  = 4'd8;
  localparam logic [3:0] CMD_ERR_MIN  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXEC      = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Command frame: [31] req toggle, [30:27] cmd, [26:0] payload
  typedef struct packed {
    logic                 req;
    logic [3:0]           cmd;
    logic [PAYLOAD_W-1:0] payload;
  } cmd_frame_t;

  // Response frame: [31] ack, [30] halted, [29] running, [28] error, [24:16] addr, [15:0] data
  typedef struct packed {
    logic                  ack;
    logic                  halted;
    logic                  running;
    logic                  error;
    logic [2:0]            rsvd;
    logic [RSP_ADDR_W-1:0] addr;
    logic [RSP_DATA_W-1:0] data;
  } rsp_frame_t;

endpackage

// File: rtl/debug_frame_if.sv
// GPIO side of debug_unit: registers the command frame, detects a pending toggle and builds the response.
// Latency: frame seen one cycle after it toggles; ack bit follows i_ack by one cycle; host waits on ack toggle.
module debug_frame_if
  import debug_unit_pkg::*;
#(
  parameter int NB_FRAME     = 32,
  parameter int NB_IMEM_ADDR = 9
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_FRAME-1:0]     i_frame,
  input  logic                    i_accept,
  input  logic                    i_ack,
  input  logic                    i_halted,
  input  logic                    i_running,
  input  logic                    i_error,
  input  logic [NB_IMEM_ADDR-1:0] i_addr,
  input  logic [RSP_DATA_W-1:0]   i_data,
  output logic                    o_pending,
  output logic [3:0]              o_cmd,
  output logic [PAYLOAD_W-1:0]    o_payload,
  output logic [NB_FRAME-1:0]     o_frame
);

  cmd_frame_t frame_q;
  logic       last_tog_q;
  logic       ack_tog_q;
  rsp_frame_t rsp;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      frame_q    <= '0;
      last_tog_q <= 1'b0;
      ack_tog_q  <= 1'b0;
    end else begin
      frame_q <= cmd_frame_t'(i_frame);
      if (i_accept) last_tog_q <= frame_q.req;
      // Echo the accepted toggle rather than flipping, so ack can never drift from req.
      if (i_ack) ack_tog_q <= last_tog_q;
    end
  end

  assign o_pending = frame_q.req ^ last_tog_q;
  assign o_cmd     = frame_q.cmd;
  assign o_payload = frame_q.payload;

  always_comb begin
    rsp         = '0;
    rsp.ack     = ack_tog_q;
    rsp.halted  = i_halted;
    rsp.running = i_running;
    rsp.error   = i_error;
    rsp.addr    = RSP_ADDR_W'(i_addr);
    rsp.data    = i_data;
  end

  assign o_frame = NB_FRAME'(rsp);

endmodule

// File: rtl/debug_unit.sv
// Debug/load controller: decodes host command frames to load imem, reset, step/run the pipeline and read debug words.
// Latency: side effects and ack two cycles after the frame is registered (READ_LO one more); RUN holds valid until halt or new request.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int  NB_FRAME     = 32,
  parameter int  NB_INSTR     = 32,
  parameter int  N_ADDR       = 512,
  parameter int  NB_DBG_SEL   = 8,
  parameter int  NB_DBG_DATA  = 32,
  localparam int NB_IMEM_ADDR = $clog2(N_ADDR)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_FRAME-1:0]     i_frame_from_blaze,
  output logic [NB_FRAME-1:0]     o_frame_to_blaze,
  output logic                    o_pipe_valid,
  output logic                    o_pipe_reset,
  output logic                    o_imem_we,
  output logic [NB_IMEM_ADDR-1:0] o_imem_addr,
  output logic [NB_INSTR-1:0]     o_imem_data,
  output logic [NB_DBG_SEL-1:0]   o_dbg_sel,
  input  logic [NB_DBG_DATA-1:0]  i_dbg_data,
  input  logic                    i_halt
);

  state_e                  state_q, state_d;
  logic                    pending, accept, ack;
  logic [3:0]              req_cmd, cmd_q;
  logic [PAYLOAD_W-1:0]    req_payload;
  logic [15:0]             payload_q;
  logic [15:0]             buf_q;
  logic [NB_IMEM_ADDR-1:0] addr_q;
  logic [15:0]             data_q;
  logic [15:0]             lat_hi_q;
  logic                    halted_q, error_q;
  logic                    unused_payload;

  assign unused_payload = ^req_payload[PAYLOAD_W-1:16];

  debug_frame_if #(.NB_FRAME(NB_FRAME), .NB_IMEM_ADDR(NB_IMEM_ADDR)) u_frame_if (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_frame   (i_frame_from_blaze),
    .i_accept  (accept),
    .i_ack     (ack),
    .i_halted  (halted_q),
    .i_running (state_q == ST_RUN),
    .i_error   (error_q),
    .i_addr    (addr_q),
    .i_data    (data_q),
    .o_pending (pending),
    .o_cmd     (req_cmd),
    .o_payload (req_payload),
    .o_frame   (o_frame_to_blaze)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ack     = 1'b0;
    case (state_q)
      ST_IDLE: if (pending) begin
        accept  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cmd_q == CMD_READ_LO) begin
          state_d = ST_READ_WAIT;
        end else begin
          ack     = 1'b1;
          state_d = (cmd_q == CMD_RUN && !halted_q) ? ST_RUN : ST_IDLE;
        end
      end
      ST_READ_WAIT: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      // A request during RUN is left pending; IDLE picks it up next cycle.
      ST_RUN: if (i_halt || pending) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cmd_q        <= '0;
      payload_q    <= '0;
      buf_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      lat_hi_q     <= '0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
      o_pipe_valid <= 1'b0;
      o_pipe_reset <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_dbg_sel    <= '0;
    end else begin
      o_pipe_valid <= 1'b0;
      o_pipe_reset <= 1'b0;
      o_imem_we    <= 1'b0;
      if (i_halt && o_pipe_valid) halted_q <= 1'b1;
      if (accept) begin
        cmd_q     <= req_cmd;
        payload_q <= req_payload[15:0];
      end
      if (ack) error_q <= (cmd_q >= CMD_ERR_MIN);
      case (state_q)
        ST_EXEC: begin
          case (cmd_q)
            CMD_PIPE_RST: begin
              o_pipe_reset <= 1'b1;
              halted_q     <= 1'b0;
            end
            CMD_ADDR_SET: addr_q <= payload_q[NB_IMEM_ADDR-1:0];
            CMD_LOAD_LO:  buf_q  <= payload_q;
            CMD_LOAD_HI: begin
              o_imem_we   <= 1'b1;
              o_imem_addr <= addr_q;
              o_imem_data <= NB_INSTR'({payload_q, buf_q});
              addr_q      <= (addr_q == NB_IMEM_ADDR'(N_ADDR - 1)) ? '0
                                                                   : addr_q + NB_IMEM_ADDR'(1);
            end
            CMD_STEP, CMD_RUN: o_pipe_valid <= !halted_q;
            CMD_READ_LO:       o_dbg_sel    <= payload_q[NB_DBG_SEL-1:0];
            CMD_READ_HI:       data_q       <= lat_hi_q;
            default: ;
          endcase
        end
        ST_READ_WAIT: begin
          lat_hi_q <= i_dbg_data[31:16];
          data_q   <= i_dbg_data[15:0];
        end
        ST_RUN: if (!(i_halt || pending)) o_pipe_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: host-side command driver with response and imem-write scoreboards.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] frame_in;
  logic [31:0] frame_out;
  logic        pipe_valid, pipe_reset, imem_we;
  logic [8:0]  imem_addr;
  logic [31:0] imem_data;
  logic [7:0]  dbg_sel;
  logic [31:0] dbg_data;
  logic        halt;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int rst_cnt = 0;
  int we_cnt = 0;

  logic [31:0] exp_rsp_q[$];
  logic [40:0] exp_imem_q[$];
  logic        prev_ack = 1'b0;

  logic        req_tog;
  logic        m_halted;
  logic        m_err;
  logic [8:0]  m_addr;
  logic [15:0] m_buf;
  logic [15:0] m_data;
  logic [31:0] m_lat;

  always #5 clk = ~clk;

  function automatic logic [31:0] dbg_word(input logic [7:0] sel);
    return (sel == 8'd3) ? 32'hDEADBEEF : {24'h0BAD00, sel};
  endfunction

  assign dbg_data = dbg_word(dbg_sel);

  debug_unit dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_frame_from_blaze (frame_in),
    .o_frame_to_blaze   (frame_out),
    .o_pipe_valid       (pipe_valid),
    .o_pipe_reset       (pipe_reset),
    .o_imem_we          (imem_we),
    .o_imem_addr        (imem_addr),
    .o_imem_data        (imem_data),
    .o_dbg_sel          (dbg_sel),
    .i_dbg_data         (dbg_data),
    .i_halt             (halt)
  );

  // Scoreboard side: every ack edge and every imem write must match the head of its queue.
  always @(negedge clk) begin
    logic [31:0] exp_f;
    logic [40:0] exp_w;
    if (!rst) begin
      if (frame_out[31] !== prev_ack) begin
        checks++;
        if (exp_rsp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected got=%h", frame_out);
        end else begin
          exp_f = exp_rsp_q.pop_front();
          if (frame_out !== exp_f) begin
            failures++;
            $display("FAIL rsp_frame got=%h want=%h", frame_out, exp_f);
          end
        end
      end
      if (imem_we === 1'b1) begin
        checks++;
        if (exp_imem_q.size() == 0) begin
          failures++;
          $display("FAIL imem_unexpected got=%h/%h", imem_addr, imem_data);
        end else begin
          exp_w = exp_imem_q.pop_front();
          if ({imem_addr, imem_data} !== exp_w) begin
            failures++;
            $display("FAIL imem_write got=%h want=%h", {imem_addr, imem_data}, exp_w);
          end
        end
      end
    end
    prev_ack = frame_out[31];
    valid_cnt += int'(pipe_valid === 1'b1);
    rst_cnt   += int'(pipe_reset === 1'b1);
    we_cnt    += int'(imem_we === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    req_tog = 1'b0; m_halted = 1'b0; m_err = 1'b0;
    m_addr = '0; m_buf = '0; m_data = '0; m_lat = '0;
  endtask

  task automatic send_cmd(input logic [3:0] cmd, input logic [26:0] payload);
    logic running;
    bit   seen;
    running = 1'b0;
    m_err   = (cmd >= 4'd9);
    case (cmd)
      4'd1: m_halted = 1'b0;
      4'd2: m_addr = payload[8:0];
      4'd3: m_buf = payload[15:0];
      4'd4: begin
        exp_imem_q.push_back({m_addr, payload[15:0], m_buf});
        m_addr = (m_addr == 9'h1FF) ? 9'h000 : m_addr + 9'd1;
      end
      4'd6: running = !m_halted;
      4'd7: begin
        m_lat  = dbg_word(payload[7:0]);
        m_data = m_lat[15:0];
      end
      4'd8: m_data = m_lat[31:16];
      default: ;
    endcase
    req_tog = ~req_tog;
    exp_rsp_q.push_back({req_tog, m_halted, running, m_err, 3'b000, m_addr, m_data});
    frame_in = {req_tog, cmd, payload};
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(1);
      if (frame_out[31] === req_tog) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ack_timeout cmd=%0d ack=%b want=%b", cmd, frame_out[31], req_tog);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; frame_in = '0;
    model_reset();
    tick(3);
    checks++;
    if (frame_out !== 32'h0) begin failures++; $display("FAIL reset_frame got=%h want=0", frame_out); end
    checks++;
    if ({pipe_valid, pipe_reset, imem_we, imem_addr, imem_data, dbg_sel} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b %h %h %h want=0", pipe_valid, pipe_reset, imem_we,
               imem_addr, imem_data, dbg_sel);
    end
    rst = 1'b0;
    tick(5);
    checks++;
    if (frame_out !== 32'h0 || valid_cnt != 0) begin
      failures++;
      $display("FAIL idle_no_request frame=%h valids=%0d want 0/0", frame_out, valid_cnt);
    end
  endtask

  task automatic test_load();
    int w0;
    w0 = we_cnt;
    send_cmd(4'd2, 27'h1FF);
    send_cmd(4'd3, 27'h5678);
    send_cmd(4'd4, 27'h1234);
    tick(2);
    checks++;
    if (we_cnt - w0 != 1) begin failures++; $display("FAIL load_we_count got=%0d want=1", we_cnt - w0); end
    checks++;
    if (frame_out[24:16] !== 9'h000) begin
      failures++; $display("FAIL load_addr_wrap got=%h want=000", frame_out[24:16]);
    end
  endtask

  task automatic test_step();
    int v0;
    v0 = valid_cnt;
    for (int k = 0; k < 3; k++) begin
      send_cmd(4'd5, 27'h0);
      checks++;
      if (frame_out[31] !== req_tog) begin
        failures++; $display("FAIL step_ack_toggle got=%b want=%b", frame_out[31], req_tog);
      end
      tick(2);
    end
    checks++;
    if (valid_cnt - v0 != 3) begin failures++; $display("FAIL step_pulses got=%0d want=3", valid_cnt - v0); end
  endtask

  task automatic test_run_halt();
    int v0, r0;
    v0 = valid_cnt;
    send_cmd(4'd6, 27'h0);
    tick(9);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    m_halted = 1'b1;
    tick(3);
    checks++;
    if (valid_cnt - v0 != 10) begin failures++; $display("FAIL run_valid_cycles got=%0d want=10", valid_cnt - v0); end
    checks++;
    if (frame_out[30:29] !== 2'b10) begin
      failures++; $display("FAIL run_halted_flags got=%b want=10", frame_out[30:29]);
    end
    v0 = valid_cnt;
    send_cmd(4'd5, 27'h0);
    tick(3);
    checks++;
    if (valid_cnt - v0 != 0) begin failures++; $display("FAIL step_when_halted got=%0d want=0", valid_cnt - v0); end
    r0 = rst_cnt;
    send_cmd(4'd1, 27'h0);
    tick(2);
    checks++;
    if (rst_cnt - r0 != 1 || frame_out[30] !== 1'b0) begin
      failures++;
      $display("FAIL pipe_rst pulses=%0d halted=%b want 1/0", rst_cnt - r0, frame_out[30]);
    end
  endtask

  task automatic test_run_nop();
    int v0;
    send_cmd(4'd6, 27'h0);
    tick(3);
    v0 = valid_cnt;
    send_cmd(4'd0, 27'h0);
    checks++;
    if (valid_cnt - v0 != 1 || pipe_valid !== 1'b0) begin
      failures++;
      $display("FAIL run_nop_drop extra=%0d valid=%b want 1/0", valid_cnt - v0, pipe_valid);
    end
    checks++;
    if (frame_out[29] !== 1'b0) begin failures++; $display("FAIL run_nop_running got=%b want=0", frame_out[29]); end
  endtask

  task automatic test_read();
    send_cmd(4'd7, 27'h3);
    checks++;
    if (dbg_sel !== 8'd3) begin failures++; $display("FAIL read_sel got=%0d want=3", dbg_sel); end
    checks++;
    if (frame_out[15:0] !== 16'hBEEF) begin failures++; $display("FAIL read_lo got=%h want=beef", frame_out[15:0]); end
    send_cmd(4'd8, 27'h0);
    checks++;
    if (frame_out[15:0] !== 16'hDEAD) begin failures++; $display("FAIL read_hi got=%h want=dead", frame_out[15:0]); end
    send_cmd(4'd12, 27'h55);
    checks++;
    if (frame_out[28] !== 1'b1) begin failures++; $display("FAIL bad_cmd_error got=%b want=1", frame_out[28]); end
    send_cmd(4'd0, 27'h0);
    checks++;
    if (frame_out[28] !== 1'b0) begin failures++; $display("FAIL error_clear got=%b want=0", frame_out[28]); end
  endtask

  task automatic test_run_reset();
    send_cmd(4'd6, 27'h0);
    tick(2);
    rst = 1'b1;
    frame_in = '0;
    model_reset();
    tick(1);
    checks++;
    if (pipe_valid !== 1'b0 || frame_out !== 32'h0) begin
      failures++; $display("FAIL reset_mid_run valid=%b frame=%h want 0/0", pipe_valid, frame_out);
    end
    rst = 1'b0;
    tick(2);
    send_cmd(4'd0, 27'h0);
    tick(2);
  endtask

  initial begin
    test_reset();
    test_load();
    test_step();
    test_run_halt();
    test_run_nop();
    test_read();
    test_run_reset();
    checks++;
    if (exp_rsp_q.size() != 0 || exp_imem_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover rsp=%0d imem=%0d want 0/0", exp_rsp_q.size(), exp_imem_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
